// File: rtl/qconv_output_states.sv
// Output-write sequencer: streams one OutH x OutW x OcLowNum tile to the output memory write port.
// Build option QCONV_OUTPUT_SKID_EN inserts a 2-entry registered skid buffer on the write port.
module qconv_output_states #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 16,
    parameter int OutH      = 4,
    parameter int OutW      = 4,
    parameter int OcLowNum  = 2,
    parameter int CntWidth  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AddrWidth-1:0] base_addr,
    output logic                 finish,
    output logic                 busy,
    input  logic                 in_valid,
    input  logic [DataWidth-1:0] in_data,
    output logic                 in_ready,
    output logic                 wr_valid,
    output logic [AddrWidth-1:0] wr_addr,
    output logic [DataWidth-1:0] wr_data,
    output logic                 wr_last,
    input  logic                 wr_ready
);
    localparam int NumBeats = OutH * OutW * OcLowNum;
    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(NumBeats - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q;
    logic [CntWidth-1:0]    cnt_q;
    logic [AddrWidth-1:0]   base_q;
    logic                   finish_q;
    logic                   busy_q;

    logic                   run;
    logic                   in_fire;
    logic                   pending;
    logic [AddrWidth-1:0]   beat_addr;
    logic                   beat_last;

    assign run       = (state_q == RUN);
    assign in_fire   = in_valid && in_ready;
    assign beat_addr = base_q + AddrWidth'(cnt_q);
    assign beat_last = (cnt_q == LastBeat);
    assign finish    = finish_q;
    assign busy      = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        base_q  <= base_addr;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        cnt_q <= cnt_q + CntWidth'(1);
                        if (beat_last) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // finish is raised on entry to DONE so it is high for exactly the DONE cycle
                    if (!pending) begin
                        state_q  <= DONE;
                        finish_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef QCONV_OUTPUT_SKID_EN
    logic                 v0_q, v1_q;
    logic [AddrWidth-1:0] a0_q, a1_q;
    logic [DataWidth-1:0] d0_q, d1_q;
    logic                 l0_q, l1_q;
    logic                 pop;

    // entry 0 is always the head; v1 implies v0, so !v1 means occupancy < 2
    assign pop      = v0_q && wr_ready;
    assign in_ready = run && !v1_q;
    assign pending  = v0_q;
    assign wr_valid = v0_q;
    assign wr_addr  = a0_q;
    assign wr_data  = d0_q;
    assign wr_last  = v0_q && l0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            a0_q <= '0;
            a1_q <= '0;
            d0_q <= '0;
            d1_q <= '0;
            l0_q <= 1'b0;
            l1_q <= 1'b0;
        end else begin
            if (pop) begin
                v0_q <= v1_q;
                a0_q <= a1_q;
                d0_q <= d1_q;
                l0_q <= l1_q;
                v1_q <= 1'b0;
            end
            if (in_fire) begin
                if (!v0_q || (pop && !v1_q)) begin
                    v0_q <= 1'b1;
                    a0_q <= beat_addr;
                    d0_q <= in_data;
                    l0_q <= beat_last;
                end else begin
                    v1_q <= 1'b1;
                    a1_q <= beat_addr;
                    d1_q <= in_data;
                    l1_q <= beat_last;
                end
            end
        end
    end
`else
    assign pending  = 1'b0;
    assign in_ready = run && wr_ready;
    assign wr_valid = run && in_valid;
    assign wr_addr  = run ? beat_addr : '0;
    assign wr_data  = run ? in_data : '0;
    assign wr_last  = wr_valid && beat_last;
`endif

endmodule

// File: tb/tb_qconv_output_states.sv
// Scoreboard bench for qconv_output_states: a default (N=32) and a 2x2x2 (N=8) instance share the stimulus.
module tb_qconv_output_states;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_r;
    logic [15:0] base_r;
    logic        iv_r;
    logic [31:0] id_r;
    logic        wrdy_r;
    int          sel;

    logic start0, start1;
    assign start0 = start_r && (sel == 0);
    assign start1 = start_r && (sel == 1);

    logic        fin0, busy0, ir0, wv0, wl0;
    logic [15:0] wa0;
    logic [31:0] wd0;
    logic        fin1, busy1, ir1, wv1, wl1;
    logic [15:0] wa1;
    logic [31:0] wd1;

    qconv_output_states u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .base_addr(base_r),
        .finish(fin0), .busy(busy0),
        .in_valid(iv_r), .in_data(id_r), .in_ready(ir0),
        .wr_valid(wv0), .wr_addr(wa0), .wr_data(wd0), .wr_last(wl0), .wr_ready(wrdy_r)
    );

    qconv_output_states #(.OutH(2), .OutW(2), .OcLowNum(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .base_addr(base_r),
        .finish(fin1), .busy(busy1),
        .in_valid(iv_r), .in_data(id_r), .in_ready(ir1),
        .wr_valid(wv1), .wr_addr(wa1), .wr_data(wd1), .wr_last(wl1), .wr_ready(wrdy_r)
    );

    logic        m_finish, m_busy, m_in_ready, m_wr_valid, m_wr_last;
    logic [15:0] m_wr_addr;
    logic [31:0] m_wr_data;
    assign m_finish   = (sel == 1) ? fin1  : fin0;
    assign m_busy     = (sel == 1) ? busy1 : busy0;
    assign m_in_ready = (sel == 1) ? ir1   : ir0;
    assign m_wr_valid = (sel == 1) ? wv1   : wv0;
    assign m_wr_last  = (sel == 1) ? wl1   : wl0;
    assign m_wr_addr  = (sel == 1) ? wa1   : wa0;
    assign m_wr_data  = (sel == 1) ? wd1   : wd0;

`ifdef QCONV_OUTPUT_SKID_EN
    localparam int Lat32 = 0;
`else
    localparam int Lat32 = 35;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [48:0] exp_q[$];
    logic [15:0] obs_addr[$];
    int k, wr_cnt, fin_cnt, fin_cyc, last_wr_cyc;

    task automatic run_tile(input int d, input logic [15:0] base, input bit rnd,
                            input int restart_at, input int stall_at, input int stall_len,
                            input int abort_after, input int tail, input int exp_lat);
        int n;
        int after;
        bit stalled;
        bit done;
        logic [48:0] e;
        sel = d;
        n = (d == 0) ? 32 : 8;
        k = 0; wr_cnt = 0; fin_cnt = 0; fin_cyc = 0; last_wr_cyc = 0;
        after = -1; done = 1'b0;
        exp_q.delete();
        obs_addr.delete();
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            start_r = (i == 0) || (i == restart_at);
            base_r  = (i == 0) ? base : 16'h5555;
            stalled = (stall_len > 0) && (i >= stall_at) && (i < stall_at + stall_len);
            wrdy_r  = stalled ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            iv_r    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            id_r    = $urandom;
            #1;
            if (m_in_ready && iv_r) begin
                exp_q.push_back({k == n - 1, base + 16'(k), id_r});
                k++;
            end
            if (m_wr_valid && wrdy_r) begin
                wr_cnt++;
                last_wr_cyc = i + 1;
                obs_addr.push_back(m_wr_addr);
                check_eq("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("write_beat", {m_wr_last, m_wr_addr, m_wr_data}, e);
                end
            end
            if (stalled && i == stall_at + stall_len - 1)
                check_eq("stall_in_ready", m_in_ready, 0);
            if (m_finish) begin
                fin_cnt++;
                if (fin_cyc == 0) fin_cyc = i + 1;
                if (after < 0) after = tail;
            end
            if (abort_after > 0 && wr_cnt == abort_after) begin
                start_r = 1'b0;
                @(posedge clk);
                #1 rst = 1'b1;
                #1;
                check_eq("abort_busy", m_busy, 0);
                check_eq("abort_wr_valid", m_wr_valid, 0);
                check_eq("abort_in_ready", m_in_ready, 0);
                repeat (3) begin
                    @(negedge clk);
                    check_eq("abort_no_finish", m_finish, 0);
                end
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (after == 0) done = 1'b1;
            else if (after > 0) after--;
        end
        start_r = 1'b0;
        check_eq("finish_seen", fin_cnt != 0, 1);
        check_eq("write_count", wr_cnt, n);
        check_eq("finish_count", fin_cnt, 1);
        check_eq("sb_empty", exp_q.size(), 0);
        check_eq("finish_after_last", fin_cyc > last_wr_cyc, 1);
        if (exp_lat > 0) check_eq("finish_latency", fin_cyc, exp_lat);
    endtask

    logic [15:0] wrap_exp [8] = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF,
                                  16'h0000, 16'h0001, 16'h0002, 16'h0003};

    initial begin
        rst = 1'b1; start_r = 1'b0; base_r = '0; iv_r = 1'b1; id_r = 32'hDEAD_BEEF;
        wrdy_r = 1'b1; sel = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_finish", m_finish, 0);
        check_eq("rst_busy", m_busy, 0);
        check_eq("rst_in_ready", m_in_ready, 0);
        check_eq("rst_wr_valid", m_wr_valid, 0);
        check_eq("rst_wr_last", m_wr_last, 0);
        check_eq("rst_wr_addr", m_wr_addr, 0);
        check_eq("rst_wr_data", m_wr_data, 0);
        rst = 1'b0;

        // full rate, then a back-to-back tile started in the IDLE cycle right after DONE
        run_tile(0, 16'h0100, 1'b0, -1, -1, 0, 0, 0, Lat32);
        check_eq("first_addr", (obs_addr.size() > 0) ? obs_addr[0] : 16'h0, 16'h0100);
        run_tile(0, 16'h0200, 1'b0, -1, -1, 0, 0, 3, Lat32);

        run_tile(1, 16'hFFFC, 1'b0, -1, -1, 0, 0, 3, 0);
        for (int j = 0; j < 8; j++)
            check_eq("wrap_addr", (j < obs_addr.size()) ? obs_addr[j] : 16'h1234, wrap_exp[j]);

        run_tile(0, 16'h2000, 1'b1, -1, -1, 0, 0, 3, 0);
        run_tile(1, 16'h0300, 1'b1, -1, -1, 0, 0, 3, 0);
        run_tile(1, 16'h0310, 1'b1, -1, -1, 0, 0, 3, 0);

        run_tile(0, 16'h0400, 1'b0, 10, -1, 0, 0, 3, Lat32);

        run_tile(1, 16'h0080, 1'b0, -1, -1, 0, 5, 3, 0);
        run_tile(1, 16'h0040, 1'b0, -1, -1, 0, 0, 3, 0);
        for (int j = 0; j < 8; j++)
            check_eq("restart_addr", (j < obs_addr.size()) ? obs_addr[j] : 16'h1234, 16'h0040 + 16'(j));

        run_tile(0, 16'h0500, 1'b0, -1, 8, 10, 0, 3, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
